block_fill_assembler: RTL

BLOCK_FILL_ASSEMBLER -- requirements
Module: block_fill_assembler

---
 rtl/block_fill_assembler.sv | 109 ++++++++++
 1 files changed

// File: rtl/block_fill_assembler.sv
`default_nettype none
// ============================================================================
// block_fill_assembler: collects one cache block, one narrow word at a time, critical word first
// Revision: 1.0
// ============================================================================
module block_fill_assembler #(
   parameter int MEM_DATA_WIDTH = 320,
   parameter int WORD_WIDTH     = 20,
   parameter int B_OFFSET_BITS  = 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_req_valid,
   input  logic [B_OFFSET_BITS-1:0]  i_req_offset,
   output logic                      o_req_ready,
   input  logic [WORD_WIDTH-1:0]     i_word,
   input  logic                      i_word_valid,
   output logic                      o_word_ready,
   output logic [WORD_WIDTH-1:0]     o_first_word,
   output logic                      o_first_word_valid,
   output logic [MEM_DATA_WIDTH-1:0] o_block,
   output logic                      o_block_valid,
   input  logic                      i_block_ready
);

   localparam int c_WORDS = 2**B_OFFSET_BITS;
   localparam logic [B_OFFSET_BITS:0] c_LAST = (B_OFFSET_BITS+1)'(c_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [B_OFFSET_BITS-1:0]  r_ptr;
   logic [B_OFFSET_BITS:0]    r_cnt;
   logic [MEM_DATA_WIDTH-1:0] r_block;
   logic [WORD_WIDTH-1:0]     r_first;
   logic                      r_first_valid;
   logic                      w_req_acc;
   logic                      w_word_acc;

   assign w_req_acc  = (r_state == S_IDLE) && i_req_valid;
   assign w_word_acc = (r_state == S_FILL) && i_word_valid;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      o_req_ready   = 1'b0;
      o_word_ready  = 1'b0;
      o_block_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_next = S_FILL;
         end
         S_FILL: begin
            o_word_ready = 1'b1;
            if (i_word_valid && (r_cnt == c_LAST)) w_next = S_DONE;
         end
         S_DONE: begin
            o_block_valid = 1'b1;
            if (i_block_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // The pointer wraps naturally at its width, giving critical-word-first order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ptr         <= '0;
         r_cnt         <= '0;
         r_block       <= '0;
         r_first       <= '0;
         r_first_valid <= 1'b0;
      end else begin
         r_first_valid <= 1'b0;
         if (w_req_acc) begin
            r_ptr   <= i_req_offset;
            r_cnt   <= '0;
            r_block <= '0;
         end else if (w_word_acc) begin
            r_block[r_ptr*WORD_WIDTH +: WORD_WIDTH] <= i_word;
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '0) begin
               r_first       <= i_word;
               r_first_valid <= 1'b1;
            end
         end
      end
   end

   assign o_block            = r_block;
   assign o_first_word       = r_first;
   assign o_first_word_valid = r_first_valid;

endmodule
`default_nettype wire
